i2c_slave_regif: RTL and testbench

//  I2C responder (slave) for write transactions: START, 7-bit addr + W, sub-address byte, data byte(s), STOP.

---
 rtl/i2c_slave_regif.sv | 218 +++++++++++++++++++++
 tb/tb_i2c_slave_regif.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_regif.sv
// i2c_slave_regif: write-only I2C responder that turns bus writes into register-file strobes.
// Optional build macro I2C_SLAVE_AUTOINC_EN: sub-address post-increments after every data strobe.
module i2c_slave_regif #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h68,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i2c_scl,
  input  logic       i2c_sda_in,
  output logic       i2c_sda_out,
  output logic       i2c_sda_out_mode,
  output logic       wr_valid,
  output logic [7:0] wr_sub,
  output logic [7:0] wr_data,
  output logic       busy,
  output logic [3:0] state_wire
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    RX_ADDR  = 4'd1,
    ACK_ADDR = 4'd2,
    RX_SUB   = 4'd3,
    ACK_SUB  = 4'd4,
    RX_DATA  = 4'd5,
    ACK_DATA = 4'd6,
    IGNORE   = 4'd7
  } state_t;

  state_t                 state_r;
  state_t                 state_nx_s;
  logic [SYNC_STAGES-1:0] scl_sync_r;
  logic [SYNC_STAGES-1:0] sda_sync_r;
  logic                   scl_s;
  logic                   sda_s;
  logic                   scl_prev_r;
  logic                   sda_prev_r;
  logic                   scl_rise_s;
  logic                   scl_fall_s;
  logic                   start_s;
  logic                   stop_s;
  logic                   rx_state_s;
  logic                   ack_state_s;
  logic                   byte_done_s;
  logic                   addr_match_s;
  logic [7:0]             byte_s;
  logic [2:0]             bit_cnt_r;
  logic [2:0]             bit_cnt_nx_s;
  logic [7:0]             shift_r;
  logic [7:0]             shift_nx_s;
  logic                   ack_drv_r;
  logic                   ack_drv_nx_s;
  logic                   sda_mode_r;
  logic                   sda_mode_nx_s;
  logic                   sda_out_r;
  logic                   wr_valid_r;
  logic                   wr_valid_nx_s;
  logic [7:0]             wr_sub_r;
  logic [7:0]             wr_sub_nx_s;
  logic [7:0]             wr_data_r;
  logic [7:0]             wr_data_nx_s;
  logic                   busy_r;
  logic                   busy_nx_s;

  function automatic logic is_rx(input state_t st);
    return (st == RX_ADDR) || (st == RX_SUB) || (st == RX_DATA);
  endfunction

  function automatic logic is_ack(input state_t st);
    return (st == ACK_ADDR) || (st == ACK_SUB) || (st == ACK_DATA);
  endfunction

  function automatic logic is_busy(input state_t st);
    return is_ack(st) || (st == RX_SUB) || (st == RX_DATA);
  endfunction

  // Input synchronisers plus one extra stage for edge detection; idle bus level is high
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_sync_r <= {SYNC_STAGES{1'b1}};
      sda_sync_r <= {SYNC_STAGES{1'b1}};
      scl_prev_r <= 1'b1;
      sda_prev_r <= 1'b1;
    end else begin
      scl_sync_r <= {scl_sync_r[SYNC_STAGES-2:0], i2c_scl};
      sda_sync_r <= {sda_sync_r[SYNC_STAGES-2:0], i2c_sda_in};
      scl_prev_r <= scl_s;
      sda_prev_r <= sda_s;
    end
  end

  assign scl_s        = scl_sync_r[SYNC_STAGES-1];
  assign sda_s        = sda_sync_r[SYNC_STAGES-1];
  assign scl_rise_s   = scl_s & ~scl_prev_r;
  assign scl_fall_s   = ~scl_s & scl_prev_r;
  assign start_s      = scl_s & scl_prev_r & sda_prev_r & ~sda_s;
  assign stop_s       = scl_s & scl_prev_r & ~sda_prev_r & sda_s;
  assign rx_state_s   = is_rx(state_r);
  assign ack_state_s  = is_ack(state_r);
  assign byte_s       = {shift_r[6:0], sda_s};
  assign byte_done_s  = scl_rise_s & (bit_cnt_r == 3'd7);
  assign addr_match_s = (byte_s[7:1] == SLAVE_ADDR) && (byte_s[0] == 1'b0);

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next state; bus START/STOP take priority over everything
  always_comb begin
    state_nx_s = state_r;
    if (stop_s) begin
      state_nx_s = IDLE;
    end else if (start_s) begin
      state_nx_s = RX_ADDR;
    end else begin
      case (state_r)
        IDLE:     state_nx_s = IDLE;
        RX_ADDR:  state_nx_s = byte_done_s ? (addr_match_s ? ACK_ADDR : IGNORE) : RX_ADDR;
        RX_SUB:   state_nx_s = byte_done_s ? ACK_SUB : RX_SUB;
        RX_DATA:  state_nx_s = byte_done_s ? ACK_DATA : RX_DATA;
        ACK_ADDR: state_nx_s = (scl_fall_s && ack_drv_r) ? RX_SUB : ACK_ADDR;
        ACK_SUB:  state_nx_s = (scl_fall_s && ack_drv_r) ? RX_DATA : ACK_SUB;
        ACK_DATA: state_nx_s = (scl_fall_s && ack_drv_r) ? RX_DATA : ACK_DATA;
        IGNORE:   state_nx_s = IGNORE;
        default:  state_nx_s = IDLE;
      endcase
    end
  end

  // Datapath and output next values; an ACK spans two SCL falls: first drives, second releases
  always_comb begin
    bit_cnt_nx_s  = bit_cnt_r;
    shift_nx_s    = shift_r;
    ack_drv_nx_s  = ack_drv_r;
    sda_mode_nx_s = sda_mode_r;
    wr_valid_nx_s = 1'b0;
    wr_sub_nx_s   = wr_sub_r;
    wr_data_nx_s  = wr_data_r;
`ifdef I2C_SLAVE_AUTOINC_EN
    if (wr_valid_r) begin
      wr_sub_nx_s = wr_sub_r + 8'd1;
    end else begin
      wr_sub_nx_s = wr_sub_r;
    end
`endif
    if (start_s || stop_s) begin
      bit_cnt_nx_s  = 3'd0;
      ack_drv_nx_s  = 1'b0;
      sda_mode_nx_s = 1'b0;
    end else if (scl_rise_s && rx_state_s) begin
      shift_nx_s   = byte_s;
      bit_cnt_nx_s = bit_cnt_r + 3'd1;
    end else if (scl_fall_s && ack_state_s) begin
      if (!ack_drv_r) begin
        ack_drv_nx_s  = 1'b1;
        sda_mode_nx_s = 1'b1;
        if (state_r == ACK_SUB) begin
          wr_sub_nx_s = shift_r;
        end else begin
          wr_sub_nx_s = wr_sub_nx_s;
        end
        if (state_r == ACK_DATA) begin
          wr_valid_nx_s = 1'b1;
          wr_data_nx_s  = shift_r;
        end else begin
          wr_valid_nx_s = 1'b0;
        end
      end else begin
        ack_drv_nx_s  = 1'b0;
        sda_mode_nx_s = 1'b0;
        bit_cnt_nx_s  = 3'd0;
      end
    end else begin
      bit_cnt_nx_s = bit_cnt_r;
    end
    busy_nx_s = is_busy(state_nx_s);
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt_r  <= 3'd0;
      shift_r    <= 8'd0;
      ack_drv_r  <= 1'b0;
      sda_mode_r <= 1'b0;
      sda_out_r  <= 1'b1;
      wr_valid_r <= 1'b0;
      wr_sub_r   <= 8'd0;
      wr_data_r  <= 8'd0;
      busy_r     <= 1'b0;
    end else begin
      bit_cnt_r  <= bit_cnt_nx_s;
      shift_r    <= shift_nx_s;
      ack_drv_r  <= ack_drv_nx_s;
      sda_mode_r <= sda_mode_nx_s;
      sda_out_r  <= ~sda_mode_nx_s;
      wr_valid_r <= wr_valid_nx_s;
      wr_sub_r   <= wr_sub_nx_s;
      wr_data_r  <= wr_data_nx_s;
      busy_r     <= busy_nx_s;
    end
  end

  assign i2c_sda_out      = sda_out_r;
  assign i2c_sda_out_mode = sda_mode_r;
  assign wr_valid         = wr_valid_r;
  assign wr_sub           = wr_sub_r;
  assign wr_data          = wr_data_r;
  assign busy             = busy_r;
  assign state_wire       = state_r;

endmodule

// File: tb/tb_i2c_slave_regif.sv
// Self-checking bench for i2c_slave_regif: bus-level master, open-drain SDA, transaction-level model.
module tb_i2c_slave_regif;

  localparam logic [6:0] SLAVE_ADDR = 7'h68;
`ifdef I2C_SLAVE_AUTOINC_EN
  localparam logic AUTOINC = 1'b1;
`else
  localparam logic AUTOINC = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       scl;
  logic       m_sda;
  logic       sda_bus;
  logic       i2c_sda_out;
  logic       i2c_sda_out_mode;
  logic       wr_valid;
  logic [7:0] wr_sub;
  logic [7:0] wr_data;
  logic       busy;
  logic [3:0] state_wire;

  int          n_cmp;
  int          n_err;
  logic        drove_any;
  logic [15:0] obs_q[$];
  logic [15:0] exp_q[$];
  logic [7:0]  dq[8];
  logic [7:0]  exp_sub;
  logic [7:0]  exp_data;

  i2c_slave_regif dut (
    .clk              (clk),
    .reset            (reset),
    .i2c_scl          (scl),
    .i2c_sda_in       (sda_bus),
    .i2c_sda_out      (i2c_sda_out),
    .i2c_sda_out_mode (i2c_sda_out_mode),
    .wr_valid         (wr_valid),
    .wr_sub           (wr_sub),
    .wr_data          (wr_data),
    .busy             (busy),
    .state_wire       (state_wire)
  );

  // Wired-AND bus: the responder can only pull low
  assign sda_bus = m_sda & ~(i2c_sda_out_mode & ~i2c_sda_out);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_valid) obs_q.push_back({wr_sub, wr_data});
    if (i2c_sda_out_mode) drove_any = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    wait_clk(2); m_sda = b;
    wait_clk(6); scl = 1'b1;
    wait_clk(8); scl = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic acked);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    wait_clk(2); m_sda = 1'b1;
    wait_clk(6); scl = 1'b1;
    wait_clk(4); acked = ~sda_bus;
    wait_clk(4); scl = 1'b0;
  endtask

  task automatic do_start();
    wait_clk(2); m_sda = 1'b1;
    wait_clk(4); scl = 1'b1;
    wait_clk(8); m_sda = 1'b0;
    wait_clk(8); scl = 1'b0;
  endtask

  task automatic do_stop();
    wait_clk(2); m_sda = 1'b0;
    wait_clk(6); scl = 1'b1;
    wait_clk(8); m_sda = 1'b1;
    wait_clk(8);
  endtask

  // One write transaction (START is repeated if the bus is already owned); model predicts acks and strobes
  task automatic txn(input logic [7:0] a, input logic [7:0] s, input int n, input logic with_stop);
    logic acked;
    logic exp_ack;
    exp_ack = (a == {SLAVE_ADDR, 1'b0});
    drove_any = 1'b0;
    exp_q.delete();
    if (exp_ack) begin
      for (int i = 0; i < n; i++) begin
        exp_q.push_back({AUTOINC ? 8'(s + 8'(i)) : s, dq[i]});
      end
      exp_sub = AUTOINC ? 8'(s + 8'(n)) : s;
      if (n > 0) exp_data = dq[n-1];
    end
    do_start();
    send_byte(a, acked);
    check("addr_ack", 32'(acked), 32'(exp_ack));
    wait_clk(4);
    check("busy_after_addr", 32'(busy), 32'(exp_ack));
    check("state_after_addr", 32'(state_wire), exp_ack ? 32'd3 : 32'd7);
    send_byte(s, acked);
    check("sub_ack", 32'(acked), 32'(exp_ack));
    for (int i = 0; i < n; i++) begin
      send_byte(dq[i], acked);
      check("data_ack", 32'(acked), 32'(exp_ack));
    end
    if (with_stop) begin
      do_stop();
      check("busy_after_stop", 32'(busy), 32'd0);
      check("state_after_stop", 32'(state_wire), 32'd0);
      check("mode_after_stop", 32'(i2c_sda_out_mode), 32'd0);
    end
    check("sda_driven", 32'(drove_any), 32'(exp_ack));
    check("strobe_count", 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      check("strobe_sub_data", 32'(obs_q[i]), 32'(exp_q[i]));
    end
    check("wr_sub_hold", 32'(wr_sub), 32'(exp_sub));
    check("wr_data_hold", 32'(wr_data), 32'(exp_data));
    obs_q.delete();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_sda_out"}, 32'(i2c_sda_out), 32'd1);
    check({tag, "_mode"}, 32'(i2c_sda_out_mode), 32'd0);
    check({tag, "_wr_valid"}, 32'(wr_valid), 32'd0);
    check({tag, "_wr_sub"}, 32'(wr_sub), 32'd0);
    check({tag, "_wr_data"}, 32'(wr_data), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_state"}, 32'(state_wire), 32'd0);
  endtask

  initial begin
    logic acked;
    logic [7:0] a;
    logic [7:0] s;
    int n;
    n_cmp = 0;
    n_err = 0;
    exp_sub = 8'd0;
    exp_data = 8'd0;
    drove_any = 1'b0;
    reset = 1'b1;
    scl = 1'b1;
    m_sda = 1'b1;
    wait_clk(3);
    check_reset_values("reset");
    reset = 1'b0;
    wait_clk(4);

    // Basic single-byte write
    dq[0] = 8'h0F;
    txn(8'hD0, 8'h20, 1, 1'b1);
    // Foreign address and read request are NACKed
    dq[0] = 8'h33;
    txn(8'hA0, 8'h20, 1, 1'b1);
    txn(8'hD1, 8'h44, 1, 1'b1);
    // Two-byte burst across the sub-address wrap
    dq[0] = 8'h11; dq[1] = 8'h22;
    txn(8'hD0, 8'hFF, 2, 1'b1);

    // Partial byte abandoned by repeated START
    obs_q.delete();
    do_start();
    send_byte(8'hD0, acked);
    check("rs_addr_ack", 32'(acked), 32'd1);
    send_byte(8'h20, acked);
    check("rs_sub_ack", 32'(acked), 32'd1);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    check("rs_no_strobe", 32'(obs_q.size()), 32'd0);
    dq[0] = 8'h55;
    txn(8'hD0, 8'h30, 1, 1'b1);

    // Randomised transactions
    for (int t = 0; t < 8; t++) begin
      a = ($urandom_range(0, 2) != 0) ? 8'hD0 : 8'($urandom);
      s = 8'($urandom);
      n = $urandom_range(0, 4);
      for (int i = 0; i < 8; i++) dq[i] = 8'($urandom);
      txn(a, s, n, 1'b1);
    end

    // Reset while the sub-address ACK is being driven
    do_start();
    send_byte(8'hD0, acked);
    for (int i = 7; i >= 0; i--) send_bit(1'b0);
    wait_clk(2); m_sda = 1'b1;
    wait_clk(4);
    check("ack_sub_driving", 32'(i2c_sda_out_mode), 32'd1);
    check("ack_sub_state", 32'(state_wire), 32'd4);
    #2 reset = 1'b1;
    #1 check_reset_values("midack");
    wait_clk(2);
    reset = 1'b0;
    wait_clk(4);
    scl = 1'b1;
    wait_clk(8);
    check_reset_values("post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
